// File: rtl/hazard_stall_unit.sv
// Load-use / multi-cycle stall and branch-flush control for the ID stage.
// Ports: ctrl_in/ctrl_out bundle, ID/EX hazard operands, stall/flush enables, perf counters.
module hazard_stall_unit #(
  parameter int CTRL_W       = 8,
  parameter int REG_AW       = 5,
  parameter int LU_STALL_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    EXT_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] REM_INIT = 2'(LU_STALL_CYC - 1);

  state_t     state, state_nx;
  logic [1:0] rem, rem_nx;

  logic lu;
  logic hold_lu;
  logic do_flush, do_ext, do_hold, do_lu;
  logic stall;

  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // An EXT_HOLD that interrupted a load-use hold resumes it.
  assign hold_lu = (state == LU_HOLD) ||
                   ((state == EXT_HOLD) && (rem != 2'd0));

  // One-hot action terms in priority order.
  assign do_flush = branch_taken;
  assign do_ext   = ext_stall & ~branch_taken;
  assign do_hold  = hold_lu & ~branch_taken & ~ext_stall;
  assign do_lu    = lu & ~hold_lu & ~branch_taken & ~ext_stall;
  assign stall    = do_ext | do_hold | do_lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  always_comb begin
    state_nx = RUN;
    rem_nx   = rem;
    unique case (1'b1)
      do_flush: begin
        state_nx = RUN;
        rem_nx   = 2'd0;
      end
      do_ext: begin
        state_nx = EXT_HOLD;
      end
      do_hold: begin
        if (rem <= 2'd1) begin
          state_nx = RUN;
          rem_nx   = 2'd0;
        end else begin
          state_nx = LU_HOLD;
          rem_nx   = rem - 2'd1;
        end
      end
      do_lu: begin
        if (LU_STALL_CYC == 1) begin
          state_nx = RUN;
          rem_nx   = 2'd0;
        end else begin
          state_nx = LU_HOLD;
          rem_nx   = REM_INIT;
        end
      end
      default: begin
        state_nx = RUN;
        rem_nx   = 2'd0;
      end
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    bubble     = 1'b1;
    ctrl_out   = '0;
    if (rst_n) begin
      pc_write   = ~stall;
      ifid_write = ~stall;
      ifid_flush = do_flush;
      bubble     = stall | do_flush;
      ctrl_out   = (stall | do_flush) ? '0 : ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (do_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: three instances (1/3/4 stall cycles)
// against a pending-hold-count model, plus literal pins.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ctrl_in;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_mem_read, branch_taken, ext_stall;

  logic [7:0]  co [3];
  logic        pw [3];
  logic        iw [3];
  logic        fl [3];
  logic        bb [3];
  logic [15:0] sca, fca, scc, fcc;
  logic [3:0]  scb, fcb;

  int vecs = 0;
  int bad  = 0;

  int ncyc [3] = '{1, 3, 4};
  int cmax [3] = '{65535, 15, 65535};
  int pend [3];
  int sc   [3];
  int fc   [3];

  always #5 clk = ~clk;

  hazard_stall_unit #(.LU_STALL_CYC(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .ctrl_out(co[0]),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_write(pw[0]), .ifid_write(iw[0]), .ifid_flush(fl[0]),
    .bubble(bb[0]), .stall_cnt(sca), .flush_cnt(fca));

  hazard_stall_unit #(.LU_STALL_CYC(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .ctrl_out(co[1]),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_write(pw[1]), .ifid_write(iw[1]), .ifid_flush(fl[1]),
    .bubble(bb[1]), .stall_cnt(scb), .flush_cnt(fcb));

  hazard_stall_unit #(.LU_STALL_CYC(4), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .ctrl_out(co[2]),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_write(pw[2]), .ifid_write(iw[2]), .ifid_flush(fl[2]),
    .bubble(bb[2]), .stall_cnt(scc), .flush_cnt(fcc));

  function automatic bit lu_now();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) ||
            (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // 0 = run, 1 = stall, 2 = flush
  function automatic int act(int i);
    if (branch_taken) return 2;
    if (ext_stall)    return 1;
    if (pend[i] > 0)  return 1;
    if (lu_now())     return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        pend[i] <= 0;
        sc[i]   <= 0;
        fc[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (act(i) == 2) begin
          pend[i] <= 0;
          if (fc[i] < cmax[i]) fc[i] <= fc[i] + 1;
        end else if (act(i) == 1) begin
          if (sc[i] < cmax[i]) sc[i] <= sc[i] + 1;
          if (!ext_stall)
            pend[i] <= (pend[i] > 0) ? pend[i] - 1 : ncyc[i] - 1;
        end
      end
    end
  end

  function automatic int scv(int i);
    case (i)
      0:       return int'(sca);
      1:       return int'(scb);
      default: return int'(scc);
    endcase
  endfunction

  function automatic int fcv(int i);
    case (i)
      0:       return int'(fca);
      1:       return int'(fcb);
      default: return int'(fcc);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic       e_pw, e_fl, e_bb;
      logic [7:0] e_co;
      if (!rst_n) begin
        e_pw = 1'b0; e_fl = 1'b0; e_bb = 1'b1;
      end else begin
        e_pw = (act(i) != 1);
        e_fl = (act(i) == 2);
        e_bb = (act(i) != 0);
      end
      e_co = e_bb ? 8'h00 : ctrl_in;
      vecs++;
      if (pw[i] !== e_pw || iw[i] !== e_pw || fl[i] !== e_fl ||
          bb[i] !== e_bb || co[i] !== e_co ||
          scv(i) != sc[i] || fcv(i) != fc[i]) begin
        bad++;
        $display("FAIL cyc dut%0d t=%0t got pw=%b iw=%b fl=%b bb=%b co=%h sc=%0d fc=%0d want pw=%b fl=%b bb=%b co=%h sc=%0d fc=%0d",
                 i, $time, pw[i], iw[i], fl[i], bb[i], co[i], scv(i), fcv(i),
                 e_pw, e_fl, e_bb, e_co, sc[i], fc[i]);
      end
    end
  endtask

  task automatic pin(string n, int got, int want);
    vecs++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", n, got, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; branch_taken = 0; ext_stall = 0;
  endtask

  task automatic hazard();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int burst;
    rst_n = 1'b0;
    ctrl_in = 8'hA5;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    pin("run_ctrl_out", int'(co[0]), 8'hA5);
    pin("run_pc_write", int'(pw[1]), 1);
    pin("run_stall_cnt", int'(sca), 0);

    hazard();
    cyc();
    idle();
    repeat (5) cyc();
    pin("lu1_stall_cnt", int'(sca), 1);
    pin("lu3_stall_cnt", int'(scb), 3);
    pin("lu4_stall_cnt", int'(scc), 4);

    do_reset();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    cyc();
    idle();
    repeat (3) cyc();
    pin("rd0_stall_cnt", int'(scb), 0);

    do_reset();
    hazard();
    cyc();
    idle();
    branch_taken = 1;
    #1;
    pin("br_flush", int'(fl[1]), 1);
    pin("br_pc_write", int'(pw[1]), 1);
    cyc();
    branch_taken = 0;
    repeat (2) cyc();
    pin("br_stall_cnt", int'(scb), 1);
    pin("br_flush_cnt", int'(fcb), 1);

    do_reset();
    ext_stall = 1;
    cyc();
    hazard();
    repeat (3) cyc();
    ext_stall = 0;
    cyc();
    idle();
    repeat (6) cyc();
    pin("ext_lu1_stall", int'(sca), 5);
    pin("ext_lu3_stall", int'(scb), 7);
    pin("ext_lu4_stall", int'(scc), 8);

    hazard();
    cyc();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    pin("rst_pc_write", int'(pw[2]), 0);
    pin("rst_bubble", int'(bb[2]), 1);
    pin("rst_ctrl_out", int'(co[2]), 0);
    pin("rst_stall_cnt", int'(scc), 0);
    cyc();
    rst_n = 1'b1;

    ext_stall = 1;
    repeat (20) cyc();
    ext_stall = 0;
    pin("sat4_stall_cnt", int'(scb), 15);
    pin("sat16_stall_cnt", int'(sca), 20);
    cyc();

    do_reset();
    burst = 0;
    repeat (3000) begin
      ctrl_in      = 8'($urandom);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      if (burst > 0) begin
        burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        burst = $urandom_range(0, 4);
      end
      ext_stall = (burst > 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Parametrised successor to the single-bit control-zeroing hazard mux in the pipelined core.
- Detects load-use hazards in ID and holds the front end for a configurable number of cycles. Also takes an external multi-cycle stall request and a taken-branch flush.
- Zeroes the CTRL_W-bit ID/EX control bundle whenever a bubble is required.
- Sits between the decoder/control unit and the ID/EX pipeline register. Drives PC and IF/ID write enables.

Parameters:
- CTRL_W, 8: width of control bundle (ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop[1:0]).
- REG_AW, 5: register address width.
- LU_STALL_CYC, 1: bubble cycles per load-use hazard. Legal range 1..4.
- CNT_W, 16: width of saturating performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_in  in  CTRL_W  control bundle from control unit
- ctrl_out  out  CTRL_W  bundle to ID/EX; all-zero when bubble=1
- id_rs1, id_rs2  in  REG_AW  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
- ex_rd  in  REG_AW  destination of instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- branch_taken  in  1  branch resolved taken (redirect this cycle)
- ext_stall  in  1  multi-cycle EX unit busy
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- bubble  out  1  ID/EX control zeroed this cycle
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating

Behaviour:
- States: RUN, LU_HOLD, EXT_HOLD. Internal down-counter rem (2 bits).
- Reset (rst_n=0, asynchronous):
  - state=RUN, rem=0, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=0, bubble=1, ctrl_out=0.
- Hazard term lu = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- All outputs are combinational from current state and inputs; zero-cycle latency. Only state, rem and the counters are registered.
- Priority each cycle: branch_taken > ext_stall > LU_HOLD/lu > normal.
- branch_taken=1, any state:
  - Outputs: ifid_flush=1, bubble=1, pc_write=1, ifid_write=1.
  - Next state=RUN, rem=0; aborts any hold.
  - flush_cnt+1.
- ext_stall=1 (no branch):
  - Outputs: pc_write=0, ifid_write=0, bubble=1.
  - Next state=EXT_HOLD; rem is preserved (not cleared).
- EXT_HOLD with ext_stall=0:
  - If rem!=0, behave as LU_HOLD this cycle.
  - Otherwise behave as RUN this cycle, lu detection included.
- RUN with lu=1:
  - Outputs: pc_write=0, ifid_write=0, bubble=1.
  - If LU_STALL_CYC=1, stay in RUN. Otherwise go to LU_HOLD with rem=LU_STALL_CYC-1.
- LU_HOLD:
  - Outputs as in RUN with lu=1, regardless of lu.
  - rem decrements each cycle; when rem reaches 1, next state=RUN.
- RUN with lu=0, no branch, no ext_stall:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=0, bubble=0, ctrl_out=ctrl_in.
- Counters:
  - stall_cnt increments on every post-reset cycle with pc_write=0.
  - Both counters saturate at all-ones, with no wrap.
- Simultaneous lu and branch_taken: the flush wins and no stall occurs; the squashed instruction's hazard is irrelevant.
- ex_rd=0 never produces a hazard.

Test Plan:
- Reset, release rst_n, no hazards, ctrl_in=8'hA5 -> ctrl_out=8'hA5, pc_write=ifid_write=1, stall_cnt=0.
- LU_STALL_CYC=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle, then ex_mem_read=0 -> exactly 1 cycle with bubble=1, ctrl_out=0, pc_write=0; stall_cnt=1.
- LU_STALL_CYC=3: same hazard for one cycle -> 3 consecutive cycles with pc_write=0, bubble=1; stall_cnt=3. Repeat with ex_rd=0 -> no stall.
- LU_STALL_CYC=3: hazard, then branch_taken=1 on the second hold cycle -> that cycle ifid_flush=1, pc_write=1; next cycle RUN; stall_cnt=1, flush_cnt=1.
- ext_stall high 4 cycles while a load-use arrives in cycle 2 -> pc_write=0 for 4 cycles; on ext_stall release, remaining LU cycles apply. Assert rst_n=0 mid-hold -> outputs go to reset values immediately, counters read 0.
- Force stall_cnt near 2^CNT_W-1 (CNT_W=4: 16 stall cycles) -> saturates at 4'hF.
